parity_err_monitor: RTL and testbench
=====================================

PARITY_ERR_MONITOR -- requirements
Module: parity_err_monitor

Interface
REQ-001 Parameter THRESH, default 3, number of parity errors within one acknowledge window that raises the alarm; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  qualifies addr/data/par for one clk cycle.
REQ-005 addr  input  4  counter address of the fetched word.
REQ-006 data  input  8  fetched data byte.
REQ-007 par  input  1  stored parity bit for data.
REQ-008 ack  input  1  software/host acknowledge of an alarm; single-cycle pulse.
REQ-009 word_cnt  output  8  count of valid words checked.
REQ-010 err_cnt  output  8  total parity errors since reset.
REQ-011 win_cnt  output  4  errors in the current acknowledge window.
REQ-012 alarm  output  1  high while FSM is in ALARM.
REQ-013 state  output  2  FSM state encoding: OK=00, WARN=01, ALARM=10.
REQ-014 err_addr  output  4  addr of the first error in the current window.
REQ-015 err_data  output  8  data of the first error in the current window.

Function
REQ-016 Error condition SHALL be: in_valid=1 and (XOR of data[7:0]) != par; a word with XOR == par is good.
REQ-017 All outputs SHALL be registered and SHALL reflect a sampled word one cycle after the in_valid edge; no combinational input-to-output path exists.
REQ-018 word_cnt SHALL increment by 1 per valid word and SHALL wrap from 255 to 0.
REQ-019 err_cnt SHALL increment by 1 per error and SHALL saturate at 255; only clear resets it.
REQ-020 win_cnt SHALL increment by 1 per error, saturate at 15, and reset to 0 on an ack taken in ALARM.
REQ-021 FSM OK -> WARN on an error when THRESH > 1.
REQ-022 FSM OK or WARN -> ALARM on the error that makes win_cnt reach THRESH; THRESH=1 goes OK -> ALARM directly.
REQ-023 ALARM SHALL persist until ack=1; ack in ALARM -> OK with win_cnt=0.
REQ-024 ack in OK or WARN SHALL be ignored: no state or counter change.
REQ-025 Simultaneous ack and error in ALARM: ack SHALL take effect first and the error SHALL open the new window (win_cnt=1, state WARN, or ALARM if THRESH=1).
REQ-026 Errors received while in ALARM SHALL still update err_cnt and win_cnt (saturating) but SHALL NOT change err_addr/err_data.
REQ-027 err_addr/err_data SHALL load only on the first error of a window (win_cnt==0 before the update) and hold until the next window's first error.
REQ-028 in_valid=0 cycles SHALL leave all state unchanged except ack handling.

Reset
REQ-029 clear=1 at a clk edge SHALL force word_cnt=0, err_cnt=0, win_cnt=0, state=OK, alarm=0, err_addr=0, err_data=0, overriding in_valid and ack in the same cycle.
REQ-030 clear asserted mid-alarm or mid-window SHALL discard all history; the first word after clear deasserts is treated as word 0.

Configuration
REQ-031 Macro PARITY_MON_CAPTURE_EN defined: err_addr/err_data capture registers per REQ-027 are present.
REQ-032 Macro PARITY_MON_CAPTURE_EN undefined: no capture registers are built; err_addr and err_data SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-033 clear=1 two cycles with in_valid=1, data=8'h03, par=1 -> all outputs 0, state=00.
REQ-034 Eight valid words {8'h1F,1},{8'h31,1},{8'h53,1},{8'h75,1},{8'h97,1},{8'hB9,1},{8'hDB,1},{8'hFD,1} -> word_cnt=8, err_cnt=0, state=OK.
REQ-035 THRESH=3, errors at addr 2 (8'h03,par 1), addr 5 (8'h05,par 1), addr 9 (8'h11,par 1) -> WARN after first, ALARM/alarm=1 one cycle after third, err_addr=2, err_data=8'h03.
REQ-036 In ALARM, ack=1 together with error at addr 4 (8'h0F,par 1) -> next cycle state=WARN, win_cnt=1, err_addr=4, err_cnt incremented.
REQ-037 300 valid error words -> err_cnt=255 (saturated), win_cnt=15, word_cnt=44 (wrapped).
REQ-038 Build without PARITY_MON_CAPTURE_EN, repeat REQ-035 -> identical state/counters, err_addr=0, err_data=0.

Source files
------------

// File: rtl/parity_err_monitor_if.sv
// ----------------------------------------------------------------------------
// parity_err_monitor_if
//
// Purpose:
//   Groups the fetched-word bus and the host acknowledge that feed the
//   parity error monitor. The producer of fetched words (and the host that
//   acknowledges alarms) uses the master modport; the monitor uses the
//   slave modport.
//
// Signals:
//   in_valid  qualifies addr/data/par for one clk cycle
//   addr[3:0] counter address of the fetched word
//   data[7:0] fetched data byte
//   par       stored parity bit for data
//   ack       single-cycle acknowledge of an alarm
// ----------------------------------------------------------------------------
interface parity_err_monitor_if;
  logic       in_valid;
  logic [3:0] addr;
  logic [7:0] data;
  logic       par;
  logic       ack;

  modport master (
    output in_valid,
    output addr,
    output data,
    output par,
    output ack
  );

  modport slave (
    input in_valid,
    input addr,
    input data,
    input par,
    input ack
  );
endinterface

// File: rtl/parity_err_monitor.sv
// ----------------------------------------------------------------------------
// parity_err_monitor
//
// Purpose:
//   Checks the parity of every valid fetched word, counts words and parity
//   errors, and runs an OK/WARN/ALARM state machine that raises an alarm
//   when THRESH errors have occurred within one acknowledge window. A window
//   starts after clear or after the host acknowledges an alarm. Optionally
//   captures the address and data of the first error of each window.
//
// Parameters:
//   THRESH  errors within one window that raise the alarm (1..15, default 3)
//
// Configuration macro:
//   PARITY_MON_CAPTURE_EN  defined   -> err_addr/err_data capture registers
//                                       are built
//                          undefined -> no capture registers; err_addr and
//                                       err_data are constant 0
//
// Ports:
//   clk             single clock, rising edge
//   clear           synchronous active-high reset
//   bus (slave)     in_valid/addr/data/par/ack, see parity_err_monitor_if
//   word_cnt[7:0]   valid words checked, wraps 255 -> 0
//   err_cnt[7:0]    parity errors since clear, saturates at 255
//   win_cnt[3:0]    errors in the current window, saturates at 15
//   alarm           high while the FSM is in ALARM
//   state[1:0]      OK=00, WARN=01, ALARM=10
//   err_addr[3:0]   addr of the first error in the current window
//   err_data[7:0]   data of the first error in the current window
//
// All outputs come straight from flops, so a sampled word is visible on the
// outputs one cycle after the edge that took it and there is no
// combinational input-to-output path.
// ----------------------------------------------------------------------------
module parity_err_monitor #(
  parameter int unsigned THRESH = 3
) (
  input  logic                        clk,
  input  logic                        clear,
  parity_err_monitor_if.slave         bus,
  output logic [7:0]                  word_cnt,
  output logic [7:0]                  err_cnt,
  output logic [3:0]                  win_cnt,
  output logic                        alarm,
  output logic [1:0]                  state,
  output logic [3:0]                  err_addr,
  output logic [7:0]                  err_data
);

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_WARN  = 2'b01,
    ST_ALARM = 2'b10
  } state_t;

  localparam logic [3:0] THRESH_W = 4'(THRESH);

  state_t     state_q, state_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] win_cnt_q, win_cnt_d;
  logic       alarm_q, alarm_d;

  logic       parity_err;
  logic       ack_taken;
  logic [3:0] base_win;
  state_t     base_state;
  logic       first_err;

  // Next-state logic. An acknowledge taken in ALARM is applied first: it
  // closes the old window (base_win/base_state) and any error in the same
  // cycle is then counted as the first error of the new window. Acks in OK
  // or WARN do nothing. Cycles without in_valid only ever see ack handling.
  always_comb begin
    parity_err = bus.in_valid && ((^bus.data) != bus.par);
    ack_taken  = bus.ack && (state_q == ST_ALARM);
    base_win   = ack_taken ? 4'd0 : win_cnt_q;
    base_state = ack_taken ? ST_OK : state_q;

    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    win_cnt_d  = base_win;
    state_d    = base_state;

    if (bus.in_valid) begin
      word_cnt_d = word_cnt_q + 8'd1;
    end

    if (parity_err) begin
      err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      win_cnt_d = (base_win == 4'hF) ? 4'hF : base_win + 4'd1;
      // Once in ALARM only an ack leaves it; further errors just count.
      if (base_state != ST_ALARM) begin
        state_d = (win_cnt_d >= THRESH_W) ? ST_ALARM : ST_WARN;
      end
    end

    // The alarm flag is registered from the next state so it lines up with
    // the state output instead of being decoded after the flop.
    alarm_d = (state_d == ST_ALARM);

    // First error of a window: the window was empty before this update and
    // we are not sitting in ALARM (errors there never overwrite capture).
    first_err = parity_err && (base_win == 4'd0) && (base_state != ST_ALARM);
  end

  // Counter and FSM registers. clear wins over any word or ack in the same
  // cycle so that all history is discarded.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_OK;
      word_cnt_q <= 8'd0;
      err_cnt_q  <= 8'd0;
      win_cnt_q  <= 4'd0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      win_cnt_q  <= win_cnt_d;
      alarm_q    <= alarm_d;
    end
  end

`ifdef PARITY_MON_CAPTURE_EN
  logic [3:0] err_addr_q, err_addr_d;
  logic [7:0] err_data_q, err_data_d;

  // Capture the first error of each window and hold it until the next
  // window's first error, so the host still sees it after acknowledging.
  always_comb begin
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    if (first_err) begin
      err_addr_d = bus.addr;
      err_data_d = bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      err_addr_q <= 4'd0;
      err_data_q <= 8'd0;
    end else begin
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_data = err_data_q;
`else
  // Without the capture option the address and first-error flag have no
  // consumer; they are folded into a sink so nothing dangles.
  logic unused_capture;
  assign unused_capture = first_err ^ (^bus.addr);

  assign err_addr = 4'd0;
  assign err_data = 8'd0;
`endif

  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign win_cnt  = win_cnt_q;
  assign alarm    = alarm_q;
  assign state    = state_q;

endmodule

// File: tb/tb_parity_err_monitor.sv
// ----------------------------------------------------------------------------
// tb_parity_err_monitor
//
// Directed bench for parity_err_monitor. A THRESH=3 instance carries most
// scenarios; a THRESH=1 instance covers the direct OK -> ALARM path.
// Expected capture values depend on PARITY_MON_CAPTURE_EN in the same way
// as the design: when the macro is undefined err_addr/err_data must be 0.
// ----------------------------------------------------------------------------
module tb_parity_err_monitor;

  logic clk;
  logic clear;

  parity_err_monitor_if bus_if ();
  parity_err_monitor_if bus1_if ();

  logic [7:0] word_cnt, err_cnt;
  logic [3:0] win_cnt, err_addr;
  logic [7:0] err_data;
  logic       alarm;
  logic [1:0] state;

  logic [7:0] w1_word_cnt, w1_err_cnt;
  logic [3:0] w1_win_cnt, w1_err_addr;
  logic [7:0] w1_err_data;
  logic       w1_alarm;
  logic [1:0] w1_state;

  int errors = 0;
  int checks = 0;

`ifdef PARITY_MON_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam logic [1:0] S_OK    = 2'b00;
  localparam logic [1:0] S_WARN  = 2'b01;
  localparam logic [1:0] S_ALARM = 2'b10;

  parity_err_monitor #(.THRESH(3)) dut (
    .clk      (clk),
    .clear    (clear),
    .bus      (bus_if),
    .word_cnt (word_cnt),
    .err_cnt  (err_cnt),
    .win_cnt  (win_cnt),
    .alarm    (alarm),
    .state    (state),
    .err_addr (err_addr),
    .err_data (err_data)
  );

  parity_err_monitor #(.THRESH(1)) dut1 (
    .clk      (clk),
    .clear    (clear),
    .bus      (bus1_if),
    .word_cnt (w1_word_cnt),
    .err_cnt  (w1_err_cnt),
    .win_cnt  (w1_win_cnt),
    .alarm    (w1_alarm),
    .state    (w1_state),
    .err_addr (w1_err_addr),
    .err_data (w1_err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] a, input logic [7:0] d,
                     input logic p, input logic k);
    bus_if.in_valid = v;
    bus_if.addr     = a;
    bus_if.data     = d;
    bus_if.par      = p;
    bus_if.ack      = k;
  endtask

  task automatic put1(input logic v, input logic [3:0] a, input logic [7:0] d,
                      input logic p, input logic k);
    bus1_if.in_valid = v;
    bus1_if.addr     = a;
    bus1_if.data     = d;
    bus1_if.par      = p;
    bus1_if.ack      = k;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    tick;
    clear = 1'b0;
  endtask

  // clear held two cycles while an erroring word and an ack are presented.
  task automatic test_reset;
    clear = 1'b1;
    put(1'b1, 4'd2, 8'h03, 1'b1, 1'b1);
    tick;
    tick;
    checks++; if (word_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_word_cnt got=%0d want=0", word_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (win_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_win_cnt got=%0d want=0", win_cnt); end
    checks++; if (state !== S_OK) begin errors++; $display("[TB] FAIL reset_state got=%b want=00", state); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarm got=%b want=0", alarm); end
    checks++; if (err_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_err_addr got=%0d want=0", err_addr); end
    checks++; if (err_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_data got=%h want=00", err_data); end
    checks++; if (w1_state !== S_OK) begin errors++; $display("[TB] FAIL reset_t1_state got=%b want=00", w1_state); end
    clear = 1'b0;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // The listed eight words, as given: 8'h53 and 8'hDB have an even number
  // of ones, so with par=1 they are parity errors (two errors, WARN, first
  // error at addr 2). Repeated with par=0 on those two, all words are good.
  task automatic test_good_words;
    logic [7:0] tab [8];
    logic       par_ok [8];
    tab    = '{8'h1F, 8'h31, 8'h53, 8'h75, 8'h97, 8'hB9, 8'hDB, 8'hFD};
    par_ok = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 4'(i), tab[i], 1'b1, 1'b0);
      tick;
    end
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    tick;
    checks++; if (word_cnt !== 8'd8) begin errors++; $display("[TB] FAIL raw_word_cnt got=%0d want=8", word_cnt); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL raw_err_cnt got=%0d want=2", err_cnt); end
    checks++; if (win_cnt !== 4'd2) begin errors++; $display("[TB] FAIL raw_win_cnt got=%0d want=2", win_cnt); end
    checks++; if (state !== S_WARN) begin errors++; $display("[TB] FAIL raw_state got=%b want=01", state); end
    checks++; if (err_data !== (CAP ? 8'h53 : 8'h00)) begin errors++; $display("[TB] FAIL raw_err_data got=%h want=%h", err_data, CAP ? 8'h53 : 8'h00); end

    do_clear;
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 4'(i), tab[i], par_ok[i], 1'b0);
      tick;
    end
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    tick;
    checks++; if (word_cnt !== 8'd8) begin errors++; $display("[TB] FAIL good_word_cnt got=%0d want=8", word_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL good_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (state !== S_OK) begin errors++; $display("[TB] FAIL good_state got=%b want=00", state); end

    // ack in OK is ignored
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (state !== S_OK || win_cnt !== 4'd0 || word_cnt !== 8'd8) begin errors++; $display("[TB] FAIL ack_in_ok got=state %b win %0d word %0d want=state 00 win 0 word 8", state, win_cnt, word_cnt); end
  endtask

  // THRESH=3: errors at addr 2, 5, 9 among good words.
  task automatic test_alarm;
    do_clear;
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      put(1'b1, 4'(i), 8'h03, 1'b1, 1'b0);
      else if (i == 5) put(1'b1, 4'(i), 8'h05, 1'b1, 1'b0);
      else if (i == 9) put(1'b1, 4'(i), 8'h11, 1'b1, 1'b0);
      else             put(1'b1, 4'(i), 8'h01, 1'b1, 1'b0);
      tick;
      if (i == 2) begin
        checks++; if (state !== S_WARN) begin errors++; $display("[TB] FAIL first_err_state got=%b want=01", state); end
        checks++; if (err_addr !== (CAP ? 4'd2 : 4'd0)) begin errors++; $display("[TB] FAIL first_err_addr got=%0d want=%0d", err_addr, CAP ? 2 : 0); end
      end
      if (i == 8) begin
        checks++; if (alarm !== 1'b0 || win_cnt !== 4'd2) begin errors++; $display("[TB] FAIL pre_alarm got=alarm %b win %0d want=alarm 0 win 2", alarm, win_cnt); end
      end
    end
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (state !== S_ALARM) begin errors++; $display("[TB] FAIL alarm_state got=%b want=10", state); end
    checks++; if (alarm !== 1'b1) begin errors++; $display("[TB] FAIL alarm_flag got=%b want=1", alarm); end
    checks++; if (win_cnt !== 4'd3 || err_cnt !== 8'd3 || word_cnt !== 8'd10) begin errors++; $display("[TB] FAIL alarm_counts got=win %0d err %0d word %0d want=win 3 err 3 word 10", win_cnt, err_cnt, word_cnt); end
    checks++; if (err_addr !== (CAP ? 4'd2 : 4'd0)) begin errors++; $display("[TB] FAIL alarm_err_addr got=%0d want=%0d", err_addr, CAP ? 2 : 0); end
    checks++; if (err_data !== (CAP ? 8'h03 : 8'h00)) begin errors++; $display("[TB] FAIL alarm_err_data got=%h want=%h", err_data, CAP ? 8'h03 : 8'h00); end

    tick; tick; tick;
    checks++; if (alarm !== 1'b1 || state !== S_ALARM) begin errors++; $display("[TB] FAIL alarm_persist got=alarm %b state %b want=alarm 1 state 10", alarm, state); end

    // error while in ALARM counts but does not recapture
    put(1'b1, 4'd7, 8'h07, 1'b0, 1'b0);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (err_cnt !== 8'd4 || win_cnt !== 4'd4) begin errors++; $display("[TB] FAIL alarm_err_count got=err %0d win %0d want=err 4 win 4", err_cnt, win_cnt); end
    checks++; if (err_addr !== (CAP ? 4'd2 : 4'd0) || err_data !== (CAP ? 8'h03 : 8'h00)) begin errors++; $display("[TB] FAIL alarm_no_recapture got=addr %0d data %h", err_addr, err_data); end
  endtask

  // ack and error in the same ALARM cycle, then ack ignored in WARN, then
  // plain ack from ALARM.
  task automatic test_ack_with_error;
    put(1'b1, 4'd4, 8'h0F, 1'b1, 1'b1);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (state !== S_WARN || alarm !== 1'b0) begin errors++; $display("[TB] FAIL ackerr_state got=state %b alarm %b want=state 01 alarm 0", state, alarm); end
    checks++; if (win_cnt !== 4'd1 || err_cnt !== 8'd5) begin errors++; $display("[TB] FAIL ackerr_counts got=win %0d err %0d want=win 1 err 5", win_cnt, err_cnt); end
    checks++; if (err_addr !== (CAP ? 4'd4 : 4'd0) || err_data !== (CAP ? 8'h0F : 8'h00)) begin errors++; $display("[TB] FAIL ackerr_capture got=addr %0d data %h", err_addr, err_data); end

    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (state !== S_WARN || win_cnt !== 4'd1) begin errors++; $display("[TB] FAIL ack_in_warn got=state %b win %0d want=state 01 win 1", state, win_cnt); end

    put(1'b1, 4'd10, 8'h00, 1'b1, 1'b0);
    tick;
    put(1'b1, 4'd11, 8'h00, 1'b1, 1'b0);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (state !== S_ALARM || win_cnt !== 4'd3) begin errors++; $display("[TB] FAIL realarm got=state %b win %0d want=state 10 win 3", state, win_cnt); end
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (state !== S_OK || win_cnt !== 4'd0 || alarm !== 1'b0) begin errors++; $display("[TB] FAIL ack_in_alarm got=state %b win %0d alarm %b want=state 00 win 0 alarm 0", state, win_cnt, alarm); end
    checks++; if (err_cnt !== 8'd7 || err_addr !== (CAP ? 4'd4 : 4'd0)) begin errors++; $display("[TB] FAIL ack_keeps got=err %0d addr %0d want=err 7 addr %0d", err_cnt, err_addr, CAP ? 4 : 0); end
  endtask

  // 300 erroring words from a clean start: 300 mod 256 = 44.
  task automatic test_saturation;
    do_clear;
    for (int i = 0; i < 300; i++) begin
      put(1'b1, 4'(i), 8'h00, 1'b1, 1'b0);
      tick;
    end
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_err_cnt got=%0d want=255", err_cnt); end
    checks++; if (win_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_win_cnt got=%0d want=15", win_cnt); end
    checks++; if (word_cnt !== 8'd44) begin errors++; $display("[TB] FAIL sat_word_cnt got=%0d want=44", word_cnt); end
    checks++; if (state !== S_ALARM) begin errors++; $display("[TB] FAIL sat_state got=%b want=10", state); end
  endtask

  // clear while in ALARM with a word and ack present discards everything.
  task automatic test_clear_mid_alarm;
    clear = 1'b1;
    put(1'b1, 4'd3, 8'h00, 1'b1, 1'b1);
    tick;
    clear = 1'b0;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (word_cnt !== 8'd0 || err_cnt !== 8'd0 || win_cnt !== 4'd0) begin errors++; $display("[TB] FAIL midclr_counts got=word %0d err %0d win %0d want=0 0 0", word_cnt, err_cnt, win_cnt); end
    checks++; if (state !== S_OK || alarm !== 1'b0) begin errors++; $display("[TB] FAIL midclr_state got=state %b alarm %b want=00 0", state, alarm); end
    put(1'b1, 4'd5, 8'h01, 1'b1, 1'b0);
    tick;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (word_cnt !== 8'd1 || err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midclr_first_word got=word %0d err %0d want=1 0", word_cnt, err_cnt); end
  endtask

  // THRESH=1: first error goes straight to ALARM; ack+error stays in ALARM
  // with a fresh window.
  task automatic test_thresh1;
    put1(1'b1, 4'd6, 8'h00, 1'b1, 1'b0);
    tick;
    put1(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (w1_state !== S_ALARM || w1_alarm !== 1'b1 || w1_win_cnt !== 4'd1) begin errors++; $display("[TB] FAIL t1_direct got=state %b alarm %b win %0d want=10 1 1", w1_state, w1_alarm, w1_win_cnt); end
    put1(1'b1, 4'd9, 8'hFF, 1'b1, 1'b1);
    tick;
    put1(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (w1_state !== S_ALARM || w1_win_cnt !== 4'd1 || w1_err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL t1_ackerr got=state %b win %0d err %0d want=10 1 2", w1_state, w1_win_cnt, w1_err_cnt); end
    checks++; if (w1_err_addr !== (CAP ? 4'd9 : 4'd0) || w1_err_data !== (CAP ? 8'hFF : 8'h00)) begin errors++; $display("[TB] FAIL t1_capture got=addr %0d data %h", w1_err_addr, w1_err_data); end
    put1(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick;
    put1(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    checks++; if (w1_state !== S_OK || w1_win_cnt !== 4'd0) begin errors++; $display("[TB] FAIL t1_ack got=state %b win %0d want=00 0", w1_state, w1_win_cnt); end
  endtask

  initial begin
    clear = 1'b0;
    put(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    put1(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    #2;
    test_reset;
    test_good_words;
    test_alarm;
    test_ack_with_error;
    test_saturation;
    test_clear_mid_alarm;
    test_thresh1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
